// File: rtl/ram_port_master_pkg.sv
// Shared types and default sizing for the RAM port master.
package ram_port_master_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/ram_port_master_req_fifo.sv
// Synchronous request FIFO; full/empty and not-full flags are registered.
module req_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_head_c,
    output logic             o_not_full,
    output logic             o_empty,
    output logic             o_empty_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW-1:0]    w_wptr_nxt;
    logic [PW-1:0]    w_rptr_nxt;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_full_nxt;

    assign w_do_push     = i_push && o_not_full;
    assign w_do_pop      = i_pop && !o_empty;
    assign w_wptr_nxt    = r_wptr + PW'(w_do_push);
    assign w_rptr_nxt    = r_rptr + PW'(w_do_pop);
    assign o_empty_nxt_c = (w_wptr_nxt == w_rptr_nxt);
    assign w_full_nxt    = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                           (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
    assign o_head_c      = r_mem[r_rptr[AW-1:0]];

    // Pointer and flag registers; pointers wrap modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            o_not_full <= 1'b1;
            o_empty    <= 1'b1;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            o_not_full <= !w_full_nxt;
            o_empty    <= o_empty_nxt_c;
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/ram_port_master.sv
// Queues read/write commands and replays them one at a time onto a RAM port.
module ram_port_master
    import ram_port_master_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do,
    output logic              busy
);

    localparam int unsigned EW = DATA_W + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [EW-1:0]     w_head;
    logic              w_head_we;
    logic              w_fifo_empty;
    logic              w_empty_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_ram_ce_nxt;
    logic              w_ram_we_nxt;
    logic [DATA_W-1:0] w_ram_di_nxt;
    logic              w_rsp_valid_nxt;
    logic              w_rsp_we_nxt;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic              w_busy_nxt;

    assign w_push    = req_valid && req_ready;
    assign w_head_we = w_head[DATA_W];

    req_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_pop         (w_pop),
        .i_wdata       ({req_we, req_wdata}),
        .o_head_c      (w_head),
        .o_not_full    (req_ready),
        .o_empty       (w_fifo_empty),
        .o_empty_nxt_c (w_empty_nxt)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_ram_ce_nxt    = ram_ce;
        w_ram_we_nxt    = ram_we;
        w_ram_di_nxt    = ram_di;
        w_rsp_valid_nxt = rsp_valid;
        w_rsp_we_nxt    = rsp_we;
        w_rsp_rdata_nxt = rsp_rdata;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // ram_do is only driven while ram_ce is high, i.e. here.
                w_rsp_rdata_nxt = ram_do;
                w_rsp_we_nxt    = ram_we;
                w_rsp_valid_nxt = 1'b1;
                w_ram_ce_nxt    = 1'b0;
                w_ram_we_nxt    = 1'b0;
                w_ram_di_nxt    = '0;
                w_state_nxt     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_ACCESS;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Launch the popped head onto the RAM port.
        if (w_pop) begin
            w_ram_ce_nxt = 1'b1;
            w_ram_we_nxt = w_head_we;
            w_ram_di_nxt = w_head_we ? w_head[DATA_W-1:0] : '0;
        end
        w_busy_nxt = (w_state_nxt != ST_IDLE) || !w_empty_nxt;
    end

    // Output registers for the RAM port, response channel and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_di    <= '0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            ram_ce    <= w_ram_ce_nxt;
            ram_we    <= w_ram_we_nxt;
            ram_di    <= w_ram_di_nxt;
            rsp_valid <= w_rsp_valid_nxt;
            rsp_we    <= w_rsp_we_nxt;
            rsp_rdata <= w_rsp_rdata_nxt;
            busy      <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_ram_port_master.sv
// Self-checking bench for ram_port_master with a single-word RAM model.
module tb_ram_port_master;

    localparam int unsigned DW = 32;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic          ram_ce;
    logic          ram_we;
    logic [DW-1:0] ram_di;
    logic          busy;
    wire  [DW-1:0] ram_do;

    logic [DW-1:0] mem = '0;

    ram_port_master #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_di    (ram_di),
        .ram_do    (ram_do),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // RAM: writes mid-cycle on the falling edge, output floats when deselected.
    assign ram_do = ram_ce ? mem : {DW{1'bz}};
    always @(negedge clk) if (ram_ce && ram_we) mem <= ram_di;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Cycle counter and chip-enable pulse bookkeeping.
    int   cyc       = 0;
    int   ce_pulses = 0;
    int   ce_last   = -100;
    int   ce_gap    = 0;
    logic ce_d      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_ce === 1'b1) chk1("ram_do_known", $isunknown(ram_do), 1'b0);
    end

    always @(negedge clk) begin
        if (ram_ce === 1'b0) begin
            chk1("idle_ram_we", ram_we, 1'b0);
            chk("idle_ram_di", ram_di, '0);
        end
        if (ram_ce === 1'b1) begin
            chk1("ce_one_cycle", ce_d, 1'b0);
            if (!ce_d) begin
                ce_pulses++;
                ce_gap  = cyc - ce_last;
                ce_last = cyc;
            end
        end
        ce_d = (ram_ce === 1'b1);
    end

    // Reference model: commands run strictly in order against one storage word.
    typedef struct packed {
        logic          we;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] model_mem = '0;

    task automatic tick();
        rsp_t e;
        if (req_valid && req_ready) begin
            if (req_we) model_mem = req_wdata;
            exp_q.push_back('{we: req_we, data: model_mem});
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk1("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk1("rsp_we", rsp_we, e.we);
                chk("rsp_rdata", rsp_rdata, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic we, input logic [DW-1:0] data);
        logic accepted;
        accepted  = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_wdata = data;
        for (int i = 0; i < 50; i++) begin
            accepted = req_ready;
            tick();
            if (accepted) break;
        end
        chk1("push_accepted", accepted, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        rsp_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_left", 32'(exp_q.size()), '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    int p0;
    int waited;

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ram_ce", ram_ce, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, '0);

        // Single write with readback
        rsp_ready = 1'b1;
        push_cmd(1'b1, 32'h0000_00AA);
        chk1("w_ce_not_yet", ram_ce, 1'b0);
        chk1("w_busy", busy, 1'b1);
        tick();
        chk1("w_ram_ce", ram_ce, 1'b1);
        chk1("w_ram_we", ram_we, 1'b1);
        chk("w_ram_di", ram_di, 32'h0000_00AA);
        tick();
        chk1("w_rsp_valid", rsp_valid, 1'b1);
        chk1("w_rsp_we", rsp_we, 1'b1);
        chk("w_rsp_rdata", rsp_rdata, 32'h0000_00AA);
        chk1("w_ce_dropped", ram_ce, 1'b0);
        tick();
        chk1("w_rsp_done", rsp_valid, 1'b0);
        chk1("w_idle", busy, 1'b0);

        // Read of a preset value
        mem       = 32'd13;
        model_mem = 32'd13;
        push_cmd(1'b0, 32'hDEAD_BEEF);
        tick();
        chk1("r_ram_ce", ram_ce, 1'b1);
        chk1("r_ram_we", ram_we, 1'b0);
        chk("r_ram_di", ram_di, '0);
        tick();
        chk1("r_rsp_valid", rsp_valid, 1'b1);
        chk1("r_rsp_we", rsp_we, 1'b0);
        chk("r_rsp_rdata", rsp_rdata, 32'd13);
        tick();

        // Five commands against a stalled response channel
        rsp_ready = 1'b0;
        p0 = ce_pulses;
        push_cmd(1'b1, 32'd11);
        push_cmd(1'b0, 32'd0);
        push_cmd(1'b1, 32'd22);
        push_cmd(1'b0, 32'd0);
        push_cmd(1'b0, 32'd0);
        chk1("stall_req_ready_low", req_ready, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("stall_ce_pulses", 32'(ce_pulses - p0), 32'd1);
        chk1("stall_rsp_valid", rsp_valid, 1'b1);
        chk1("stall_busy", busy, 1'b1);
        drain(60);
        chk("stall_total_ce", 32'(ce_pulses - p0), 32'd5);

        // Write then read back-to-back
        rsp_ready = 1'b1;
        p0 = ce_pulses;
        push_cmd(1'b1, 32'h1234_5678);
        push_cmd(1'b0, 32'd0);
        drain(30);
        chk("wr_ce_pulses", 32'(ce_pulses - p0), 32'd2);
        chk("wr_ce_spacing", 32'(ce_gap), 32'd2);

        // Reset while a response is pending with two commands queued
        rsp_ready = 1'b0;
        push_cmd(1'b1, 32'h0000_0055);
        push_cmd(1'b0, 32'd0);
        push_cmd(1'b0, 32'd0);
        waited = 0;
        while (!rsp_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk1("rr_rsp_pending", rsp_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk1("rr_rsp_valid", rsp_valid, 1'b0);
        chk1("rr_busy", busy, 1'b0);
        chk1("rr_req_ready", req_ready, 1'b1);
        chk("rr_rsp_rdata", rsp_rdata, '0);
        p0 = ce_pulses;
        for (int i = 0; i < 4; i++) tick();
        chk("rr_no_ce", 32'(ce_pulses - p0), 32'd0);
        rsp_ready = 1'b1;
        push_cmd(1'b0, 32'd0);
        drain(20);

        // Randomized traffic against the in-order model
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        req_valid = 1'b0;
        drain(100);
        chk1("rand_busy_end", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
